idct_prod_accum: RTL and testbench

- Sits directly downstream of the configurable-precision multiplier wrapper in the approximate IDCT datapath.
- Consumes the wrapper's 32-bit registered product P, one product per accepted beat.
- Accumulates TERMS products per IDCT output coefficient, then rounds, shifts and saturates the sum.
- Delivers coefficients through a 2-entry output FIFO with a valid/ready handshake toward the transpose/store stage.

---
 rtl/idct_prod_accum.sv | 203 ++++++++++++++++++++
 tb/tb_idct_prod_accum.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_prod_accum.sv
// idct_prod_accum
// Accumulates TERMS signed products from the multiplier wrapper into one IDCT
// output coefficient, then rounds half-up, arithmetic-shifts by SHIFT and
// narrows to OUT_WIDTH. Results leave through a 2-entry FIFO.
//
// Build option: define IDCT_PROD_ACCUM_SAT_EN to clamp the narrowed result to
// the signed OUT_WIDTH range. Without it the result wraps to its low OUT_WIDTH
// bits. Either way ovf_sticky latches any clip or wrap until reset.
//
// Handshakes (valid/ready on both sides): a transfer happens on a rising clk
// edge where valid && ready are both high. Valid must not depend on ready.
// Input side: p_valid/p_ready carry p_in and grp_start.
// Output side: coef_valid/coef_ready carry coef_out, the FIFO head.
//
// The FSM state is visible for debug on the state_dbg output.
module idct_prod_accum #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 36,
  parameter int TERMS     = 8,
  parameter int SHIFT     = 13,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstP,
  input  logic [IN_WIDTH-1:0]  p_in,
  input  logic                 p_valid,
  output logic                 p_ready,
  input  logic                 grp_start,
  output logic [OUT_WIDTH-1:0] coef_out,
  output logic                 coef_valid,
  input  logic                 coef_ready,
  output logic                 ovf_sticky,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = $clog2(TERMS + 1);

  // Rounding constant: one half of an output LSB.
  localparam logic [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  // Signed OUT_WIDTH bounds, held at the width of the shifted sum.
  localparam logic signed [ACC_WIDTH:0] MAX_V =
    {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_V = ~MAX_V;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCUM     = 2'd1,
    S_ROUND     = 2'd2,
    S_FULL_WAIT = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]         acc_q, acc_d;
  logic [OUT_WIDTH-1:0]         mem_q [2];
  logic [OUT_WIDTH-1:0]         mem_d [2];
  logic                         rd_ptr_q, rd_ptr_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic [1:0]                   fifo_cnt_q, fifo_cnt_d;
  logic                         ovf_q, ovf_d;

  logic                         accept;
  logic                         push;
  logic                         pop;
  logic                         slot_free;
  logic [ACC_WIDTH-1:0]         p_sext;
  logic signed [ACC_WIDTH:0]    rnd_sum;
  logic signed [ACC_WIDTH:0]    shifted;
  logic [OUT_WIDTH-1:0]         r_val;
  logic                         r_ovf;

  assign p_ready    = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign accept     = p_valid && p_ready;
  assign p_sext     = {{(ACC_WIDTH - IN_WIDTH){p_in[IN_WIDTH-1]}}, p_in};
  assign coef_valid = (fifo_cnt_q != 2'd0);
  assign pop        = coef_valid && coef_ready;
  // A full FIFO still has room when its head leaves in the same cycle.
  assign slot_free  = (fifo_cnt_q != 2'd2) || pop;
  assign coef_out   = coef_valid ? mem_q[rd_ptr_q] : '0;
  assign ovf_sticky = ovf_q;
  assign busy       = (state_q != S_IDLE) || coef_valid;
  assign state_dbg  = state_q;

  // Round and narrow the accumulator; acc_q is frozen in ROUND/FULL_WAIT, so
  // this result is stable for as long as the push is pending.
  always_comb begin
    rnd_sum = $signed({acc_q[ACC_WIDTH-1], acc_q}) + $signed(HALF);
    shifted = rnd_sum >>> SHIFT;
    r_val   = shifted[OUT_WIDTH-1:0];
    r_ovf   = 1'b0;
`ifdef IDCT_PROD_ACCUM_SAT_EN
    if (shifted > MAX_V) begin
      r_val = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      r_ovf = 1'b1;
    end else if (shifted < MIN_V) begin
      r_val = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
      r_ovf = 1'b1;
    end
`else
    r_ovf = (shifted != {{(ACC_WIDTH + 1 - OUT_WIDTH){r_val[OUT_WIDTH-1]}}, r_val});
`endif
  end

  // Group FSM: next state, accumulator, term count and the FIFO push request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The first beat always opens a group, whatever grp_start says.
        if (accept) begin
          acc_d   = p_sext;
          cnt_d   = CNT_W'(1);
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (grp_start) begin
            // Early group start: drop the partial sum and restart here.
            acc_d = p_sext;
            cnt_d = CNT_W'(1);
          end else begin
            acc_d = acc_q + p_sext;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_W'(TERMS)) begin
              state_d = S_ROUND;
            end
          end
        end
      end
      S_ROUND: begin
        if (slot_free) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_FULL_WAIT;
        end
      end
      S_FULL_WAIT: begin
        if (slot_free) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output FIFO bookkeeping and the sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    ovf_d      = ovf_q;
    if (push) begin
      mem_d[wr_ptr_q] = r_val;
      wr_ptr_d        = ~wr_ptr_q;
      ovf_d           = ovf_q | r_ovf;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rstP) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_idct_prod_accum.sv
// Testbench for idct_prod_accum (default parameters).
module tb_idct_prod_accum;

  localparam int TERMS = 8;

  logic        clk = 1'b0;
  logic        rstP;
  logic [31:0] p_in;
  logic        p_valid;
  logic        p_ready;
  logic        grp_start;
  logic [15:0] coef_out;
  logic        coef_valid;
  logic        coef_ready;
  logic        ovf_sticky;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_q [$];

  idct_prod_accum dut (
    .clk        (clk),
    .rstP       (rstP),
    .p_in       (p_in),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .grp_start  (grp_start),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .ovf_sticky (ovf_sticky),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: sum the group as plain integers, wrap to 36 bits,
  // round half-up by floor((s + 4096) / 8192), then clamp or wrap to 16 bits.
  function automatic void model_group(input logic [31:0] ps [TERMS],
                                      output logic [15:0] coef, output bit ovf);
    longint m = longint'(1) << 36;
    longint s = 0;
    longint q;
    longint r;
    logic [15:0] t;
    for (int i = 0; i < TERMS; i++) s += longint'($signed(ps[i]));
    s = ((s % m) + m) % m;
    if (s >= m / 2) s -= m;
    q = s + 4096;
    if (q >= 0) r = q / 8192;
    else        r = -((-q + 8191) / 8192);
`ifdef IDCT_PROD_ACCUM_SAT_EN
    if (r > 32767)       begin coef = 16'h7FFF; ovf = 1'b1; end
    else if (r < -32768) begin coef = 16'h8000; ovf = 1'b1; end
    else                 begin coef = 16'(r);   ovf = 1'b0; end
`else
    t    = 16'(r);
    coef = t;
    ovf  = (longint'($signed(t)) != r);
`endif
  endfunction

  // Scoreboard: every coefficient leaving the DUT is compared with the queue head.
  always @(negedge clk) begin
    if (!rstP && coef_valid && coef_ready) begin
      if (exp_q.size() == 0) chk("unexpected_coef", {48'd0, coef_out}, 64'hDEAD);
      else chk("coef_out", {48'd0, coef_out}, {48'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rstP      = 1'b1;
    p_valid   = 1'b0;
    grp_start = 1'b0;
    p_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    rstP = 1'b0;
    exp_q.delete();
  endtask

  // Present one beat; returns one time-step after the edge that accepted it.
  task automatic send_beat(input logic [31:0] d, input logic gs);
    int waited = 0;
    p_in      = d;
    grp_start = gs;
    p_valid   = 1'b1;
    @(negedge clk);
    while (!p_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!p_ready) chk("beat_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    p_valid   = 1'b0;
    grp_start = 1'b0;
  endtask

  task automatic send_group(input logic [31:0] ps [TERMS]);
    for (int i = 0; i < TERMS; i++) send_beat(ps[i], i == 0);
  endtask

  task automatic drain();
    int waited = 0;
    coef_ready = 1'b1;
    while ((exp_q.size() != 0 || coef_valid) && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [31:0] a;     // beats 1..7
    logic [31:0] b;     // beat 8
    logic [15:0] coef;
    logic        ovf;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] grp [TERMS];
  logic [15:0] m_coef;
  bit          m_ovf;
  bit          ovf_acc;
  bit          rand_done;

  initial begin
    rstP       = 1'b1;
    p_valid    = 1'b0;
    grp_start  = 1'b0;
    p_in       = '0;
    coef_ready = 1'b0;

    vecs[0] = '{a: 32'h0000_1000, b: 32'h0000_1000, coef: 16'd4,      ovf: 1'b0};
    vecs[1] = '{a: 32'h0000_0200, b: 32'h0000_0200, coef: 16'd1,      ovf: 1'b0};
    vecs[2] = '{a: 32'hFFFF_FE00, b: 32'hFFFF_FE00, coef: 16'd0,      ovf: 1'b0};
    vecs[3] = '{a: 32'hFFFF_FE00, b: 32'hFFFF_FDFF, coef: 16'hFFFF,   ovf: 1'b0};
`ifdef IDCT_PROD_ACCUM_SAT_EN
    vecs[4] = '{a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, coef: 16'h7FFF,   ovf: 1'b1};
`else
    // Rounded sum is exactly 2^21, whose low 16 bits are zero.
    vecs[4] = '{a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, coef: 16'h0000,   ovf: 1'b1};
`endif

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_p_ready",    64'(p_ready),    64'd1);
    chk("rst_coef_valid", 64'(coef_valid), 64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_ovf",        64'(ovf_sticky), 64'd0);
    chk("rst_coef_out",   64'(coef_out),   64'd0);
    @(posedge clk);
    #1;

    // Table vectors: value and exact 2-cycle latency, FIFO held (coef_ready=0)
    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < TERMS; i++) send_beat((i == TERMS - 1) ? vecs[v].b : vecs[v].a, i == 0);
      @(negedge clk);
      chk("lat_round_valid", 64'(coef_valid), 64'd0);
      @(negedge clk);
      chk("lat_push_valid",  64'(coef_valid), 64'd1);
      chk("vec_coef",        64'(coef_out),   64'(vecs[v].coef));
      chk("vec_ovf",         64'(ovf_sticky), 64'(vecs[v].ovf));
      @(posedge clk);
      #1;
    end

    // FIFO full: three groups with coef_ready low, third stalls in FULL_WAIT
    do_reset();
    coef_ready = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      for (int i = 0; i < TERMS; i++) grp[i] = 32'(g) * 32'h2000;
      exp_q.push_back(16'(8 * g));
      send_group(grp);
      if (g == 1) begin
        @(negedge clk);
        @(negedge clk);
        chk("full_g1_valid", 64'(coef_valid), 64'd1);
        @(posedge clk);
        #1;
      end
    end
    repeat (4) @(negedge clk);
    chk("full_p_ready", 64'(p_ready),    64'd0);
    chk("full_busy",    64'(busy),       64'd1);
    chk("full_head",    64'(coef_out),   64'd8);
    @(posedge clk);
    #1;
    coef_ready = 1'b1;
    @(posedge clk);
    #1;
    coef_ready = 1'b0;
    @(negedge clk);
    chk("full_after_pop_p_ready", 64'(p_ready),    64'd1);
    chk("full_after_pop_valid",   64'(coef_valid), 64'd1);
    chk("full_after_pop_head",    64'(coef_out),   64'd16);
    @(posedge clk);
    #1;
    drain();

    // Reset in the middle of a group
    do_reset();
    coef_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(32'h0001_0000, i == 0);
    do_reset();
    @(negedge clk);
    chk("midrst_p_ready",    64'(p_ready),    64'd1);
    chk("midrst_busy",       64'(busy),       64'd0);
    chk("midrst_coef_valid", 64'(coef_valid), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < TERMS; i++) grp[i] = 32'(i + 1) * 32'h0000_0400;
    model_group(grp, m_coef, m_ovf);
    exp_q.push_back(m_coef);
    send_group(grp);
    drain();

    // Early grp_start on beat 4 discards the first three beats
    do_reset();
    coef_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(32'h0100_0000, i == 0);
    for (int i = 0; i < TERMS; i++) grp[i] = 32'hFFFF_F000 + 32'(i * 100);
    model_group(grp, m_coef, m_ovf);
    exp_q.push_back(m_coef);
    send_group(grp);
    drain();

    // Randomized groups, random gaps and random downstream stalls
    do_reset();
    ovf_acc   = 1'b0;
    rand_done = 1'b0;
    fork
      begin
        for (int g = 0; g < 40; g++) begin
          for (int i = 0; i < TERMS; i++) begin
            if (g % 2 == 0) grp[i] = 32'($signed($urandom_range(0, 2 * 1048576)) - 1048576);
            else            grp[i] = $urandom;
          end
          model_group(grp, m_coef, m_ovf);
          exp_q.push_back(m_coef);
          ovf_acc |= m_ovf;
          for (int i = 0; i < TERMS; i++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            send_beat(grp[i], i == 0);
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          coef_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    chk("rand_ovf_sticky", 64'(ovf_sticky), 64'(ovf_acc));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
